// File: rtl/rvc_asap_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module   : rvc_asap_mem_dump
//  Purpose  : End-of-test data-memory dump engine. On ebreak or a Start pulse
//             it freezes the core, reads BASE_ADDR..BASE_ADDR+4*NUM_WORDS-1
//             through the front-door read port and streams each word out on
//             a valid/ready channel while keeping a running checksum.
//  Revision : 1.0  initial release
// ============================================================================
module rvc_asap_mem_dump #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter int          NUM_WORDS = 1024
) (
   input  logic        Clock,
   input  logic        Rst,
   input  logic [31:0] Instruction,
   input  logic        Start,
   output logic        Halt,
   output logic        MemRdEn,
   output logic [31:0] MemRdAddr,
   input  logic [31:0] MemRdData,
   output logic        DumpValid,
   input  logic        DumpReady,
   output logic [31:0] DumpAddr,
   output logic [31:0] DumpData,
   output logic        DumpLast,
   output logic        Done,
   output logic [31:0] Checksum
);

   localparam logic [31:0] EBREAK   = 32'h0010_0073;
   // 17-bit index so that NUM_WORDS = 2^16 is representable as a count
   localparam logic [16:0] LAST_IDX = 17'(NUM_WORDS - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_SEND = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]  state;
   logic [31:0] addr;
   logic [16:0] count;
   logic [31:0] data;
   logic [31:0] checksum;

   logic        trigger;
   logic        is_last;
   logic        in_send;

   assign trigger = Start || (Instruction == EBREAK);
   assign is_last = (count == LAST_IDX);
   assign in_send = (state == S_SEND);

   // Dump sequencer: one READ/WAIT/SEND round per word, sticky DONE
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state    <= S_IDLE;
         addr     <= '0;
         count    <= '0;
         data     <= '0;
         checksum <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (trigger) begin
                  state    <= S_READ;
                  addr     <= BASE_ADDR;
                  count    <= '0;
                  checksum <= '0;
               end
            end
            S_READ: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               // Read data arrives one cycle after the strobe
               data  <= MemRdData;
               state <= S_SEND;
            end
            S_SEND: begin
               if (DumpReady) begin
                  checksum <= checksum + data;
                  addr     <= addr + 32'd4;
                  count    <= count + 17'd1;
                  state    <= is_last ? S_DONE : S_READ;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode from state; data-path outputs are forced to zero when idle
   assign Halt      = (state != S_IDLE);
   assign MemRdEn   = (state == S_READ);
   assign MemRdAddr = (state == S_READ) ? addr : 32'd0;
   assign DumpValid = in_send;
   assign DumpAddr  = in_send ? addr : 32'd0;
   assign DumpData  = in_send ? data : 32'd0;
   assign DumpLast  = in_send && is_last;
   assign Done      = (state == S_DONE);
   assign Checksum  = checksum;

endmodule
`default_nettype wire

// File: tb/tb_rvc_asap_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvc_asap_mem_dump
//  Purpose  : Directed self-checking bench for rvc_asap_mem_dump with a
//             4-word window at 0x1000 and a one-cycle-latency memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rvc_asap_mem_dump;

   logic        Clock = 1'b0;
   logic        Rst = 1'b1;
   logic [31:0] Instruction = 32'h0000_0013;
   logic        Start = 1'b0;
   logic        Halt;
   logic        MemRdEn;
   logic [31:0] MemRdAddr;
   logic [31:0] MemRdData = 32'd0;
   logic        DumpValid;
   logic        DumpReady = 1'b0;
   logic [31:0] DumpAddr;
   logic [31:0] DumpData;
   logic        DumpLast;
   logic        Done;
   logic [31:0] Checksum;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [4];
   logic [31:0] rd_q [$];
   logic [31:0] out_addr_q [$];
   logic [31:0] out_data_q [$];
   logic        out_last_q [$];

   rvc_asap_mem_dump #(.BASE_ADDR(32'h0000_1000), .NUM_WORDS(4)) dut (
      .Clock(Clock), .Rst(Rst), .Instruction(Instruction), .Start(Start),
      .Halt(Halt), .MemRdEn(MemRdEn), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
      .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpAddr(DumpAddr),
      .DumpData(DumpData), .DumpLast(DumpLast), .Done(Done), .Checksum(Checksum)
   );

   always #5 Clock = ~Clock;

   // Memory model: data valid the cycle after the strobe, junk otherwise
   logic [31:0] mem_off;
   assign mem_off = MemRdAddr - 32'h0000_1000;
   always @(posedge Clock) begin
      if (MemRdEn) MemRdData <= mem[mem_off[3:2]];
      else         MemRdData <= 32'hDEAD_BEEF;
   end

   // Monitor: record read strobes and accepted words mid-cycle
   always @(negedge Clock) begin
      if (!Rst) begin
         if (MemRdEn) rd_q.push_back(MemRdAddr);
         if (DumpValid && DumpReady) begin
            out_addr_q.push_back(DumpAddr);
            out_data_q.push_back(DumpData);
            out_last_q.push_back(DumpLast);
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      Start = 1'b0;
      Instruction = 32'h0000_0013;
      DumpReady = 1'b0;
      tick();
      tick();
      Rst = 1'b0;
      rd_q.delete();
      out_addr_q.delete();
      out_data_q.delete();
      out_last_q.delete();
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!Done && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (!Done) begin
         errors++;
         $display("FAIL wait_done: Done=%0b after %0d cycles, required 1", Done, n);
      end
   endtask

   task automatic check_stream(input string tag, input logic [31:0] sum_exp);
      logic [31:0] exp_addr;
      checks++;
      if (out_data_q.size() !== 4 || rd_q.size() !== 4) begin
         errors++;
         $display("FAIL %s_count: words=%0d reads=%0d, required 4 and 4",
                  tag, out_data_q.size(), rd_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp_addr = 32'h1000 + 32'(4 * i);
            checks++;
            if (rd_q[i] !== exp_addr || out_addr_q[i] !== exp_addr ||
                out_data_q[i] !== mem[i] || out_last_q[i] !== (i == 3)) begin
               errors++;
               $display("FAIL %s_word%0d: rd=%h addr=%h data=%h last=%0b, required %h %h %h %0b",
                        tag, i, rd_q[i], out_addr_q[i], out_data_q[i], out_last_q[i],
                        exp_addr, exp_addr, mem[i], (i == 3));
            end
         end
      end
      checks++;
      if (Checksum !== sum_exp || Halt !== 1'b1 || DumpValid !== 1'b0 || MemRdEn !== 1'b0) begin
         errors++;
         $display("FAIL %s_final: sum=%h halt=%0b valid=%0b rden=%0b, required %h 1 0 0",
                  tag, Checksum, Halt, DumpValid, MemRdEn, sum_exp);
      end
   endtask

   task automatic test_reset();
      tick();
      checks++;
      if ({Halt, MemRdEn, DumpValid, DumpLast, Done} !== 5'b0 ||
          MemRdAddr !== 32'd0 || DumpAddr !== 32'd0 || DumpData !== 32'd0 || Checksum !== 32'd0) begin
         errors++;
         $display("FAIL reset: halt=%0b rden=%0b valid=%0b last=%0b done=%0b rda=%h da=%h dd=%h sum=%h, required all 0",
                  Halt, MemRdEn, DumpValid, DumpLast, Done, MemRdAddr, DumpAddr, DumpData, Checksum);
      end
   endtask

   task automatic test_basic();
      int n;
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
      do_reset();
      DumpReady = 1'b1;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      checks++;
      if (Halt !== 1'b1 || MemRdEn !== 1'b1 || MemRdAddr !== 32'h1000) begin
         errors++;
         $display("FAIL basic_first_read: halt=%0b rden=%0b addr=%h, required 1 1 00001000",
                  Halt, MemRdEn, MemRdAddr);
      end
      wait_done(n);
      checks++;
      if (n + 1 !== 13) begin
         errors++;
         $display("FAIL basic_done_latency: %0d cycles after trigger, required 13", n + 1);
      end
      check_stream("basic", 32'd10);
   endtask

   task automatic test_ebreak();
      int n;
      do_reset();
      DumpReady = 1'b1;
      Instruction = 32'h0000_0073;
      tick();
      Instruction = 32'h0000_0013;
      checks++;
      if (Halt !== 1'b0 || MemRdEn !== 1'b0) begin
         errors++;
         $display("FAIL ecall_no_trigger: halt=%0b rden=%0b, required 0 0", Halt, MemRdEn);
      end
      Instruction = 32'h0010_0073;
      tick();
      Instruction = 32'h0000_0013;
      checks++;
      if (Halt !== 1'b1 || MemRdAddr !== 32'h1000) begin
         errors++;
         $display("FAIL ebreak_trigger: halt=%0b addr=%h, required 1 00001000", Halt, MemRdAddr);
      end
      wait_done(n);
      check_stream("ebreak", 32'd10);
   endtask

   task automatic test_backpressure();
      int n;
      int reads_before;
      logic [31:0] hold_addr, hold_data;
      do_reset();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      n = 0;
      while (!DumpValid && n < 20) begin tick(); n++; end
      DumpReady = 1'b1;
      tick();
      DumpReady = 1'b0;
      n = 0;
      while (!DumpValid && n < 20) begin tick(); n++; end
      hold_addr = DumpAddr;
      hold_data = DumpData;
      reads_before = rd_q.size();
      checks++;
      if (hold_addr !== 32'h1004 || hold_data !== 32'd2 || Checksum !== 32'd1) begin
         errors++;
         $display("FAIL bp_word1: addr=%h data=%h sum=%h, required 00001004 00000002 00000001",
                  hold_addr, hold_data, Checksum);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (DumpValid !== 1'b1 || DumpAddr !== 32'h1004 || DumpData !== 32'd2 ||
             Checksum !== 32'd1 || MemRdEn !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall%0d: valid=%0b addr=%h data=%h sum=%h rden=%0b, required 1 00001004 00000002 00000001 0",
                     i, DumpValid, DumpAddr, DumpData, Checksum, MemRdEn);
         end
      end
      checks++;
      if (rd_q.size() !== reads_before) begin
         errors++;
         $display("FAIL bp_extra_read: reads=%0d, required %0d", rd_q.size(), reads_before);
      end
      DumpReady = 1'b1;
      tick();
      checks++;
      if (Checksum !== 32'd3) begin
         errors++;
         $display("FAIL bp_after_handshake: sum=%h, required 00000003", Checksum);
      end
      wait_done(n);
      check_stream("bp", 32'd10);
   endtask

   task automatic test_wrap();
      int n;
      mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0002; mem[2] = 32'd0; mem[3] = 32'd0;
      do_reset();
      DumpReady = 1'b1;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done(n);
      check_stream("wrap", 32'h0000_0001);
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
   endtask

   task automatic test_retrigger_reset();
      int n;
      do_reset();
      Start = 1'b1;
      tick();                        // now READ
      tick();                        // Start held in READ; now WAIT
      Start = 1'b0;
      checks++;
      if (MemRdEn !== 1'b0 || rd_q.size() !== 1) begin
         errors++;
         $display("FAIL retrig_read: rden=%0b reads=%0d, required 0 1", MemRdEn, rd_q.size());
      end
      tick();                        // now SEND, not accepted
      Start = 1'b1;
      tick();
      Start = 1'b0;
      checks++;
      if (DumpValid !== 1'b1 || DumpAddr !== 32'h1000 || DumpData !== 32'd1) begin
         errors++;
         $display("FAIL retrig_send: valid=%0b addr=%h data=%h, required 1 00001000 00000001",
                  DumpValid, DumpAddr, DumpData);
      end
      DumpReady = 1'b1;
      wait_done(n);
      check_stream("retrig", 32'd10);
      Start = 1'b1;
      Instruction = 32'h0010_0073;
      tick();
      tick();
      Start = 1'b0;
      Instruction = 32'h0000_0013;
      checks++;
      if (Done !== 1'b1 || MemRdEn !== 1'b0 || Checksum !== 32'd10 || out_data_q.size() !== 4) begin
         errors++;
         $display("FAIL retrig_done: done=%0b rden=%0b sum=%h words=%0d, required 1 0 0000000a 4",
                  Done, MemRdEn, Checksum, out_data_q.size());
      end

      // Reset in SEND with a nonzero checksum already accumulated
      do_reset();
      DumpReady = 1'b1;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick(); tick(); tick();        // word0 accepted, now READ word1
      tick(); tick();                // now SEND word1
      DumpReady = 1'b0;
      #2;
      Rst = 1'b1;
      #1;
      checks++;
      if ({Halt, MemRdEn, DumpValid, DumpLast, Done} !== 5'b0 ||
          DumpAddr !== 32'd0 || DumpData !== 32'd0 || Checksum !== 32'd0) begin
         errors++;
         $display("FAIL rst_in_send: halt=%0b rden=%0b valid=%0b last=%0b done=%0b da=%h dd=%h sum=%h, required all 0",
                  Halt, MemRdEn, DumpValid, DumpLast, Done, DumpAddr, DumpData, Checksum);
      end
      tick();
      rd_q.delete();
      out_addr_q.delete();
      out_data_q.delete();
      out_last_q.delete();
      Rst = 1'b0;
      Start = 1'b1;
      DumpReady = 1'b1;
      tick();
      Start = 1'b0;
      checks++;
      if (Halt !== 1'b1 || MemRdAddr !== 32'h1000 || Checksum !== 32'd0) begin
         errors++;
         $display("FAIL redump_start: halt=%0b addr=%h sum=%h, required 1 00001000 00000000",
                  Halt, MemRdAddr, Checksum);
      end
      wait_done(n);
      check_stream("redump", 32'd10);
   endtask

   initial begin
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
      test_reset();
      test_basic();
      test_ebreak();
      test_backpressure();
      test_wrap();
      test_retrigger_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
